program_fetch_arbiter: RTL and testbench

//  Shares one single-port, 1-cycle-latency program memory between RT-Core and GP-Core fetch units.
//  RT-Core has fixed priority. A wait timer bounds GP-Core starvation.
//  An RT lock input gives hard-deterministic RT windows.

---
 rtl/mak_mem_pkg.sv | 16 +
 rtl/gp_wait_timer.sv | 40 ++++
 rtl/program_fetch_arbiter.sv | 105 ++++++++++
 tb/tb_program_fetch_arbiter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mak_mem_pkg.sv
// Shared program-memory types: read-return owner tag and common widths.
package mak_mem_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_RT   = 2'd1,
    OWN_GP   = 2'd2
  } mem_owner_e;

  localparam logic [15:0] INSTR_NOP = 16'hF000;

  localparam int unsigned WAIT_W   = 8;
  localparam int unsigned STAT_W   = 32;
  localparam int unsigned STARVE_W = 16;

endpackage

// File: rtl/gp_wait_timer.sv
// Counts consecutive denied GP-Core fetch cycles and raises force_c once the
// configured limit is reached; frozen while the RT lock is held.
module gp_wait_timer
  import mak_mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              gp_req,
  input  logic              gp_gnt,
  input  logic              rt_lock,
  input  logic [WAIT_W-1:0] limit,
  output logic              force_c
);

  logic [WAIT_W-1:0] cnt_q;
  logic [WAIT_W-1:0] cnt_d;

  // Clearing takes precedence over the lock hold so an abandoned request never leaves a stale count.
  always_comb begin
    cnt_d = cnt_q;
    if (!gp_req || gp_gnt) begin
      cnt_d = '0;
    end else if (rt_lock) begin
      cnt_d = cnt_q;
    end else if (cnt_q < limit) begin
      cnt_d = cnt_q + WAIT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign force_c = gp_req & ~rt_lock & (cnt_q == limit);

endmodule

// File: rtl/program_fetch_arbiter.sv
// Arbitrates one single-port, 1-cycle-latency program memory between the RT-Core
// and GP-Core fetch units: RT fixed priority, bounded GP starvation, RT lock windows.
module program_fetch_arbiter
  import mak_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned GP_MAX_WAIT = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rt_req,
  input  logic [ADDR_WIDTH-1:0] rt_addr,
  output logic                  rt_gnt,
  output logic [DATA_WIDTH-1:0] rt_rdata,
  output logic                  rt_rvalid,
  input  logic                  gp_req,
  input  logic [ADDR_WIDTH-1:0] gp_addr,
  output logic                  gp_gnt,
  output logic [DATA_WIDTH-1:0] gp_rdata,
  output logic                  gp_rvalid,
  input  logic                  rt_lock,
  output logic                  mem_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [STAT_W-1:0]     rt_grant_count,
  output logic [STAT_W-1:0]     gp_grant_count,
  output logic [STARVE_W-1:0]   starve_count
);

  logic               rt_req_v;
  logic               gp_req_v;
  logic               force_c;
  mem_owner_e         owner_q;
  mem_owner_e         owner_d;
  logic [STAT_W-1:0]  rt_cnt_q;
  logic [STAT_W-1:0]  gp_cnt_q;
  logic [STARVE_W-1:0] starve_q;

  // Requests are qualified by reset so no grant is visible while rst_n is low.
  assign rt_req_v = rt_req & rst_n;
  assign gp_req_v = gp_req & rst_n;

  gp_wait_timer u_wait (
    .clk     (clk),
    .rst_n   (rst_n),
    .gp_req  (gp_req_v),
    .gp_gnt  (gp_gnt),
    .rt_lock (rt_lock),
    .limit   (WAIT_W'(GP_MAX_WAIT)),
    .force_c (force_c)
  );

  assign gp_gnt   = gp_req_v & ~rt_lock & (force_c | ~rt_req_v);
  assign rt_gnt   = rt_req_v & ~gp_gnt;
  assign mem_en   = rt_gnt | gp_gnt;
  assign mem_addr = gp_gnt ? gp_addr : (rt_gnt ? rt_addr : '0);

  // Tag who owns the read data returning next cycle.
  always_comb begin
    owner_d = OWN_NONE;
    if (gp_gnt) begin
      owner_d = OWN_GP;
    end else if (rt_gnt) begin
      owner_d = OWN_RT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q <= OWN_NONE;
    end else begin
      owner_q <= owner_d;
    end
  end

  assign rt_rvalid = (owner_q == OWN_RT);
  assign gp_rvalid = (owner_q == OWN_GP);
  assign rt_rdata  = mem_rdata;
  assign gp_rdata  = mem_rdata;

  // Grant statistics: grant counts wrap, forced-grant count saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rt_cnt_q <= '0;
      gp_cnt_q <= '0;
      starve_q <= '0;
    end else begin
      if (rt_gnt) begin
        rt_cnt_q <= rt_cnt_q + STAT_W'(1);
      end
      if (gp_gnt) begin
        gp_cnt_q <= gp_cnt_q + STAT_W'(1);
      end
      if (gp_gnt && force_c && (starve_q != {STARVE_W{1'b1}})) begin
        starve_q <= starve_q + STARVE_W'(1);
      end
    end
  end

  assign rt_grant_count = rt_cnt_q;
  assign gp_grant_count = gp_cnt_q;
  assign starve_count   = starve_q;

endmodule

// File: tb/tb_program_fetch_arbiter.sv
// Directed self-checking bench for program_fetch_arbiter with a 1-cycle memory model.
module tb_program_fetch_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rt_req = 1'b0;
  logic [15:0] rt_addr = '0;
  logic        rt_gnt;
  logic [15:0] rt_rdata;
  logic        rt_rvalid;
  logic        gp_req = 1'b0;
  logic [15:0] gp_addr = '0;
  logic        gp_gnt;
  logic [15:0] gp_rdata;
  logic        gp_rvalid;
  logic        rt_lock = 1'b0;
  logic        mem_en;
  logic [15:0] mem_addr;
  logic [15:0] mem_rdata = '0;
  logic [31:0] rt_grant_count;
  logic [31:0] gp_grant_count;
  logic [15:0] starve_count;

  int n_cmp = 0;
  int n_bad = 0;

  program_fetch_arbiter #(
    .ADDR_WIDTH(16), .DATA_WIDTH(16), .GP_MAX_WAIT(3)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .rt_req(rt_req), .rt_addr(rt_addr), .rt_gnt(rt_gnt), .rt_rdata(rt_rdata), .rt_rvalid(rt_rvalid),
    .gp_req(gp_req), .gp_addr(gp_addr), .gp_gnt(gp_gnt), .gp_rdata(gp_rdata), .gp_rvalid(gp_rvalid),
    .rt_lock(rt_lock), .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .rt_grant_count(rt_grant_count), .gp_grant_count(gp_grant_count), .starve_count(starve_count)
  );

  always #5 clk = ~clk;

  // Memory model: data = addr ^ A5A5, one cycle after the enable.
  always @(posedge clk) begin
    if (mem_en) mem_rdata <= mem_addr ^ 16'hA5A5;
  end

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0; rt_req = 1'b0; gp_req = 1'b0; rt_lock = 1'b0;
    rt_addr = '0; gp_addr = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rt_req = 1'b1; rt_addr = 16'h1234;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      n_cmp++;
      if ({rt_gnt, gp_gnt, rt_rvalid, gp_rvalid, mem_en} !== 5'b0) begin
        n_bad++; $display("FAIL reset_ctrl: got %b want 00000", {rt_gnt, gp_gnt, rt_rvalid, gp_rvalid, mem_en});
      end
      n_cmp++;
      if ({rt_grant_count, gp_grant_count, starve_count} !== 80'b0) begin
        n_bad++; $display("FAIL reset_counts: got %h/%h/%h want 0", rt_grant_count, gp_grant_count, starve_count);
      end
    end
    @(negedge clk); rst_n = 1'b1; #1;
    n_cmp++;
    if (rt_gnt !== 1'b1 || mem_addr !== 16'h1234) begin
      n_bad++; $display("FAIL reset_first_gnt: got gnt=%b addr=%h want 1/1234", rt_gnt, mem_addr);
    end
    @(negedge clk); rt_req = 1'b0; #1;
    n_cmp++;
    if (rt_rvalid !== 1'b1 || rt_rdata !== 16'hB791 || gp_rvalid !== 1'b0) begin
      n_bad++; $display("FAIL reset_first_data: got v=%b d=%h gv=%b want 1/b791/0", rt_rvalid, rt_rdata, gp_rvalid);
    end
  endtask

  task automatic test_gp_only();
    logic [15:0] exp_d;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); gp_req = 1'b1; gp_addr = 16'h0010 + 16'(i); #1;
      n_cmp++;
      if (gp_gnt !== 1'b1 || rt_gnt !== 1'b0 || mem_addr !== gp_addr) begin
        n_bad++; $display("FAIL gp_only_gnt[%0d]: got gnt=%b addr=%h want 1/%h", i, gp_gnt, mem_addr, gp_addr);
      end
      if (i > 0) begin
        exp_d = (16'h0010 + 16'(i - 1)) ^ 16'hA5A5;
        n_cmp++;
        if (gp_rvalid !== 1'b1 || gp_rdata !== exp_d) begin
          n_bad++; $display("FAIL gp_only_data[%0d]: got v=%b d=%h want 1/%h", i, gp_rvalid, gp_rdata, exp_d);
        end
      end
    end
    @(negedge clk); gp_req = 1'b0; #1;
    n_cmp++;
    if (gp_rvalid !== 1'b1 || gp_rdata !== 16'hA5B6 || gp_grant_count !== 32'd4) begin
      n_bad++; $display("FAIL gp_only_last: got v=%b d=%h cnt=%0d want 1/a5b6/4", gp_rvalid, gp_rdata, gp_grant_count);
    end
  endtask

  task automatic test_contention();
    logic exp_gp;
    logic prev_gp;
    logic [15:0] exp_d;
    apply_reset();
    prev_gp = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk); rt_req = 1'b1; gp_req = 1'b1; rt_addr = 16'h0100; gp_addr = 16'h0200; #1;
      exp_gp = ((c % 4) == 3);
      n_cmp++;
      if (gp_gnt !== exp_gp || rt_gnt !== ~exp_gp) begin
        n_bad++; $display("FAIL contention_gnt[%0d]: got rt=%b gp=%b want gp=%b", c, rt_gnt, gp_gnt, exp_gp);
      end
      n_cmp++;
      if (rt_rvalid && gp_rvalid) begin
        n_bad++; $display("FAIL contention_both_rvalid[%0d]: got 1/1 want not both", c);
      end
      if (c > 0) begin
        exp_d = (prev_gp ? 16'h0200 : 16'h0100) ^ 16'hA5A5;
        n_cmp++;
        if (gp_rvalid !== prev_gp || rt_rvalid !== ~prev_gp || mem_rdata !== exp_d) begin
          n_bad++; $display("FAIL contention_ret[%0d]: got rv=%b gv=%b d=%h want gv=%b d=%h", c, rt_rvalid, gp_rvalid, mem_rdata, prev_gp, exp_d);
        end
      end
      prev_gp = exp_gp;
    end
    @(negedge clk); rt_req = 1'b0; gp_req = 1'b0; #1;
    n_cmp++;
    if (starve_count !== 16'd2 || gp_grant_count !== 32'd2 || rt_grant_count !== 32'd6) begin
      n_bad++; $display("FAIL contention_counts: got s=%0d g=%0d r=%0d want 2/2/6", starve_count, gp_grant_count, rt_grant_count);
    end
  endtask

  task automatic test_lock();
    apply_reset();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); rt_lock = 1'b1; rt_req = 1'b1; gp_req = 1'b1; #1;
      n_cmp++;
      if (rt_gnt !== 1'b1 || gp_gnt !== 1'b0) begin
        n_bad++; $display("FAIL lock_gnt[%0d]: got rt=%b gp=%b want 1/0", c, rt_gnt, gp_gnt);
      end
    end
    // Timer held at 0 through the lock, so RT still wins right after release.
    @(negedge clk); rt_lock = 1'b0; #1;
    n_cmp++;
    if (rt_gnt !== 1'b1 || gp_gnt !== 1'b0 || rt_grant_count !== 32'd10 || gp_grant_count !== 32'd0) begin
      n_bad++; $display("FAIL lock_release_cold: got rt=%b gp=%b rc=%0d gc=%0d want 1/0/10/0", rt_gnt, gp_gnt, rt_grant_count, gp_grant_count);
    end
    apply_reset();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); rt_req = 1'b1; gp_req = 1'b1; rt_lock = (c >= 3); #1;
      n_cmp++;
      if (rt_gnt !== 1'b1 || gp_gnt !== 1'b0) begin
        n_bad++; $display("FAIL lock_preload[%0d]: got rt=%b gp=%b want 1/0", c, rt_gnt, gp_gnt);
      end
    end
    @(negedge clk); rt_lock = 1'b0; #1;
    n_cmp++;
    if (gp_gnt !== 1'b1 || rt_gnt !== 1'b0) begin
      n_bad++; $display("FAIL lock_release_force: got rt=%b gp=%b want 0/1", rt_gnt, gp_gnt);
    end
    @(negedge clk); rt_req = 1'b0; gp_req = 1'b0; #1;
    n_cmp++;
    if (starve_count !== 16'd1 || gp_rvalid !== 1'b1) begin
      n_bad++; $display("FAIL lock_release_stats: got s=%0d gv=%b want 1/1", starve_count, gp_rvalid);
    end
  endtask

  task automatic test_reset_inflight();
    apply_reset();
    @(negedge clk); gp_req = 1'b1; gp_addr = 16'h0030; #1;
    n_cmp++;
    if (gp_gnt !== 1'b1) begin
      n_bad++; $display("FAIL inflight_gnt: got %b want 1", gp_gnt);
    end
    #2; rst_n = 1'b0; gp_req = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (gp_rvalid !== 1'b0 || gp_grant_count !== 32'd0) begin
      n_bad++; $display("FAIL inflight_drop: got gv=%b gc=%0d want 0/0", gp_rvalid, gp_grant_count);
    end
    @(negedge clk); rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      n_cmp++;
      if (gp_rvalid !== 1'b0 || rt_rvalid !== 1'b0 || gp_grant_count !== 32'd0 || starve_count !== 16'd0) begin
        n_bad++; $display("FAIL inflight_after[%0d]: got gv=%b rv=%b gc=%0d s=%0d want 0", c, gp_rvalid, rt_rvalid, gp_grant_count, starve_count);
      end
    end
  endtask

  task automatic test_saturation();
    apply_reset();
    @(negedge clk);
    force dut.starve_q = 16'hFFFE;
    #1;
    release dut.starve_q;
    n_cmp++;
    if (starve_count !== 16'hFFFE) begin
      n_bad++; $display("FAIL sat_preload: got %h want fffe", starve_count);
    end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk); rt_req = 1'b1; gp_req = 1'b1; #1;
      if (c == 4) begin
        n_cmp++;
        if (starve_count !== 16'hFFFF || gp_grant_count !== 32'd1) begin
          n_bad++; $display("FAIL sat_reach: got s=%h gc=%0d want ffff/1", starve_count, gp_grant_count);
        end
      end
    end
    @(negedge clk); rt_req = 1'b0; gp_req = 1'b0; #1;
    n_cmp++;
    if (starve_count !== 16'hFFFF || gp_grant_count !== 32'd2) begin
      n_bad++; $display("FAIL sat_hold: got s=%h gc=%0d want ffff/2", starve_count, gp_grant_count);
    end
  endtask

  initial begin
    test_reset();
    test_gp_only();
    test_contention();
    test_lock();
    test_reset_inflight();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
